reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter INIT_MODE, default 1, meaning 0 = entries init to zero, 1 = entry i inits to (i+1) truncated to DATA_W.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clr_req  input  1  single-cycle request to re-run the init sweep.
REQ-007 SHALL have port busy  output  1  high while the init sweep runs.
REQ-008 SHALL have port rd_en  input  1  read enable for both read ports.
REQ-009 SHALL have ports rd_addr1, rd_addr2  input  ADDR_W  read addresses.
REQ-010 SHALL have ports rd_data1, rd_data2  output  DATA_W  registered read data.
REQ-011 SHALL have port rd_valid  output  1  high for one cycle when rd_data1/2 were updated by an accepted read.
REQ-012 SHALL have ports wr_en  input  1, wr_addr  input  ADDR_W, wr_data  input  DATA_W  write request.

Function
REQ-013 SHALL implement FSM states SWEEP and IDLE; rst_n low forces SWEEP with sweep counter = 0.
REQ-014 In SWEEP, SHALL write init value for entry cnt each cycle, increment cnt, and go to IDLE in the cycle after cnt = DEPTH-1 is written (DEPTH cycles total).
REQ-015 busy SHALL equal 1 exactly when state = SWEEP.
REQ-016 In IDLE, clr_req = 1 SHALL move to SWEEP with cnt = 0 next cycle.
REQ-017 clr_req in SWEEP SHALL be ignored; sweep neither restarts nor extends.
REQ-018 Writes SHALL be synchronous: in IDLE with wr_en = 1 and clr_req = 0, entry[wr_addr] <= wr_data at the rising edge.
REQ-019 wr_en in SWEEP, or coincident with clr_req in IDLE, SHALL be dropped with no array change.
REQ-020 A read SHALL be accepted when state = IDLE, rd_en = 1 and clr_req = 0; rd_data1/2 update at that edge (1-cycle latency) and rd_valid = 1 next cycle.
REQ-021 Read with rd_en = 0, in SWEEP, or coincident with clr_req SHALL leave rd_data1/2 holding prior values, rd_valid = 0.
REQ-022 Write-first bypass: accepted read with accepted write to same address in same cycle SHALL return wr_data on that port, independently per port.
REQ-023 rd_addr1 = rd_addr2 SHALL return identical data on both ports.
REQ-024 All arithmetic on cnt SHALL be ADDR_W+1 bits wide so DEPTH-1 terminal detection is free of wrap ambiguity.

Reset
REQ-025 On rst_n low: state = SWEEP, cnt = 0, busy = 1, rd_data1 = rd_data2 = 0, rd_valid = 0, asynchronously.
REQ-026 Array contents SHALL NOT be reset asynchronously; they become defined only via the sweep.
REQ-027 rst_n asserted mid-sweep SHALL restart the sweep from cnt = 0 after release.
REQ-028 rst_n asserted mid-write SHALL leave the targeted entry to be overwritten by the sweep.

Verification
REQ-029 Reset release, defaults -> busy = 1 for exactly 16 cycles, then 0; read addr 0/15 -> 1/16, rd_valid one cycle.
REQ-030 IDLE: write 0xDEADBEEF to 5, next cycle read addr1 = 5, addr2 = 5 -> both 0xDEADBEEF one cycle later.
REQ-031 Same cycle write 0x12345678 to 3 and read addr1 = 3, addr2 = 4 -> rd_data1 = 0x12345678, rd_data2 = 5.
REQ-032 Write 0xAA to 2, pulse clr_req with wr_en to 7 = 0x55 -> busy 16 cycles; entry 2 reads 3, entry 7 reads 8.
REQ-033 Assert rst_n low at sweep cycle 9, release -> busy 16 more cycles; rd_data1/2 = 0 until first accepted read.
REQ-034 INIT_MODE = 0, DATA_W = 8, ADDR_W = 3 -> busy 8 cycles, all entries read 0x00; write 0xFF to 7 reads 0xFF.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port register file with a two-read, one-write array.
// An init sweep runs after reset and on clr_req; reads are registered.
module reg_file_mp #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int INIT_MODE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W + 1)'(1);

  typedef enum logic {SWEEP, IDLE} state_t;

  state_t            state;
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] init_val;
  logic              wr_acc;
  logic              rd_acc;
  logic              byp1;
  logic              byp2;

  assign busy   = (state == SWEEP);
  assign wr_acc = (state == IDLE) && wr_en && !clr_req;
  assign rd_acc = (state == IDLE) && rd_en && !clr_req;
  assign byp1   = wr_acc && (wr_addr == rd_addr1);
  assign byp2   = wr_acc && (wr_addr == rd_addr2);

  // Entry i starts as i+1 (wide add, then truncated) or as zero
  assign init_val = (INIT_MODE != 0) ? DATA_W'(cnt + ONE) : '0;

  // Sweep/idle sequencing with the wide sweep counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SWEEP;
      cnt   <= '0;
    end else begin
      unique case (state)
        SWEEP: begin
          cnt <= cnt + ONE;
          if (cnt == LAST) state <= IDLE;
        end
        IDLE: begin
          if (clr_req) begin
            state <= SWEEP;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

  // Array update: sweep owns the array while busy, else accepted writes
  always_ff @(posedge clk) begin
    if (state == SWEEP) mem[cnt[ADDR_W-1:0]] <= init_val;
    else if (wr_acc)    mem[wr_addr]         <= wr_data;
  end

  // Registered read ports with write-first bypass per port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data1 <= byp1 ? wr_data : mem[rd_addr1];
        rd_data2 <= byp2 ? wr_data : mem[rd_addr2];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default and small zero-init instances.
// Read expectations queue up when issued and retire when rd_valid fires.
module tb_reg_file_mp;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic        clr_a, busy_a, rd_en_a, rv_a, we_a;
  logic [3:0]  ra1_a, ra2_a, wa_a;
  logic [31:0] rd1_a, rd2_a, wd_a;

  logic        clr_b, busy_b, rd_en_b, rv_b, we_b;
  logic [2:0]  ra1_b, ra2_b, wa_b;
  logic [7:0]  rd1_b, rd2_b, wd_b;

  exp_t qa[$];
  exp_t qb[$];
  bit   pva, pvb;
  int   tests, fails;

  reg_file_mp dut_a (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_a), .busy(busy_a),
    .rd_en(rd_en_a), .rd_addr1(ra1_a), .rd_addr2(ra2_a),
    .rd_data1(rd1_a), .rd_data2(rd2_a), .rd_valid(rv_a),
    .wr_en(we_a), .wr_addr(wa_a), .wr_data(wd_a)
  );

  reg_file_mp #(.DATA_W(8), .ADDR_W(3), .INIT_MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_b), .busy(busy_b),
    .rd_en(rd_en_b), .rd_addr1(ra1_b), .rd_addr2(ra2_b),
    .rd_data1(rd1_b), .rd_data2(rd2_b), .rd_valid(rv_b),
    .wr_en(we_b), .wr_addr(wa_b), .wr_data(wd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    clr_a = 0; rd_en_a = 0; we_a = 0;
    clr_b = 0; rd_en_b = 0; we_b = 0;
    pva = 0; pvb = 0;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    chk("rv_a", {31'b0, rv_a}, {31'b0, pva});
    if (pva && qa.size() > 0) begin
      e = qa.pop_front();
      chk("rd1_a", rd1_a, e.d1);
      chk("rd2_a", rd2_a, e.d2);
    end
    chk("rv_b", {31'b0, rv_b}, {31'b0, pvb});
    if (pvb && qb.size() > 0) begin
      e = qb.pop_front();
      chk("rd1_b", {24'b0, rd1_b}, e.d1);
      chk("rd2_b", {24'b0, rd2_b}, e.d2);
    end
    idle_inputs();
  endtask

  task automatic rd_a(input logic [3:0] a1, input logic [3:0] a2,
                      input logic [31:0] e1, input logic [31:0] e2);
    rd_en_a = 1; ra1_a = a1; ra2_a = a2;
    qa.push_back('{e1, e2});
    pva = 1;
  endtask

  task automatic rd_b(input logic [2:0] a1, input logic [2:0] a2,
                      input logic [31:0] e1, input logic [31:0] e2);
    rd_en_b = 1; ra1_b = a1; ra2_b = a2;
    qb.push_back('{e1, e2});
    pvb = 1;
  endtask

  task automatic wr_a(input logic [3:0] a, input logic [31:0] d);
    we_a = 1; wa_a = a; wd_a = d;
  endtask

  // Counts cycles until busy drops; reads offered meanwhile must be refused
  task automatic count_busy(input string tag, input bit s,
                            input int exp_n, input bit poke);
    int n;
    n = 0;
    while ((s ? busy_b : busy_a) && n < 100) begin
      if (s) begin
        rd_en_b = 1; ra1_b = 1; ra2_b = 2;
      end else begin
        rd_en_a = 1; ra1_a = 1; ra2_a = 2;
      end
      if (poke && n == 4) clr_a = 1;
      if (poke && n == 10) wr_a(4'd2, 32'h77);
      tick();
      n++;
    end
    chk(tag, n, exp_n);
  endtask

  initial begin
    tests = 0; fails = 0;
    ra1_a = 0; ra2_a = 0; wa_a = 0; wd_a = 0;
    ra1_b = 0; ra2_b = 0; wa_b = 0; wd_b = 0;
    idle_inputs();
    rst_n = 1;
    #1 rst_n = 0;
    #2;
    chk("rst_busy_a", {31'b0, busy_a}, 1);
    chk("rst_rd1_a", rd1_a, 0);
    chk("rst_rd2_a", rd2_a, 0);
    chk("rst_rv_a", {31'b0, rv_a}, 0);
    chk("rst_busy_b", {31'b0, busy_b}, 1);
    chk("rst_rd1_b", {24'b0, rd1_b}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;

    count_busy("sweep_len_a", 0, 16, 0);
    chk("hold_rd1_a", rd1_a, 0);
    rd_a(4'd0, 4'd15, 32'd1, 32'd16);
    tick();
    tick();
    chk("valid_1cyc", {31'b0, rv_a}, 0);
    chk("hold_after_rd", rd2_a, 32'd16);

    wr_a(4'd5, 32'hDEADBEEF);
    tick();
    rd_a(4'd5, 4'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    tick();

    wr_a(4'd3, 32'h12345678);
    rd_a(4'd3, 4'd4, 32'h12345678, 32'd5);
    tick();
    wr_a(4'd9, 32'hCAFE);
    rd_a(4'd1, 4'd9, 32'd2, 32'hCAFE);
    tick();
    rd_a(4'd3, 4'd9, 32'h12345678, 32'hCAFE);
    tick();

    wr_a(4'd2, 32'hAA);
    tick();
    rd_a(4'd2, 4'd0, 32'hAA, 32'd1);
    tick();
    clr_a = 1;
    wr_a(4'd7, 32'h55);
    rd_en_a = 1; ra1_a = 7; ra2_a = 2;
    tick();
    chk("clr_busy", {31'b0, busy_a}, 1);
    count_busy("clr_sweep_len", 0, 16, 1);
    rd_a(4'd2, 4'd7, 32'd3, 32'd8);
    tick();
    rd_a(4'd5, 4'd3, 32'd6, 32'd4);
    tick();

    clr_a = 1;
    tick();
    repeat (9) tick();
    chk("mid_busy", {31'b0, busy_a}, 1);
    rst_n = 0;
    #2;
    chk("mid_rst_rd1", rd1_a, 0);
    chk("mid_rst_rd2", rd2_a, 0);
    tick();
    rst_n = 1;
    count_busy("rst_sweep_len", 0, 16, 0);
    chk("post_rst_rd1", rd1_a, 0);
    chk("post_rst_rd2", rd2_a, 0);
    rd_a(4'd7, 4'd9, 32'd8, 32'd10);
    tick();

    clr_b = 1;
    tick();
    count_busy("sweep_len_b", 1, 8, 0);
    for (int i = 0; i < 8; i += 2) begin
      rd_b(3'(i), 3'(i + 1), 32'h0, 32'h0);
      tick();
    end
    we_b = 1; wa_b = 7; wd_b = 8'hFF;
    tick();
    rd_b(3'd7, 3'd6, 32'hFF, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
